input_ctrl: RTL

Keyboard-to-control front end for the game datapath: it turns the USB keycode report into the frame-stable `left`/`right` levels and a one-cycle `fire` pulse. The player sprite logic consumes `left`/`right`, and the projectile logic consumes `fire`. All decisions are taken once per frame on the synchronized rising edge of `frame_clk`, so motion and firing are frame-quantized and glitch-free.

---
 rtl/input_ctrl_pkg.sv | 44 ++++
 rtl/input_ctrl_frame_tick_gen.sv | 48 ++++
 rtl/input_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/input_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_ctrl_pkg
//  Description : Shared keycode constants, direction state type and the
//                keycode slot scan helper for the keyboard control front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_ctrl_pkg;

    // USB HID usage codes for the keys the game cares about
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    // Number of 8-bit keycode slots in one report word
    localparam int unsigned NUM_SLOTS = 4;

    // Direction FSM states
    typedef enum logic [1:0] {
        D_NONE  = 2'd0,
        D_LEFT  = 2'd1,
        D_RIGHT = 2'd2
    } dir_t;

    // True when any slot carries either of the two given codes. Slot order
    // and duplicates do not matter; an empty slot (8'h00) never matches
    // because none of the game keys use code zero.
    function automatic logic key_held(input logic [31:0] codes,
                                      input logic [7:0]  code_a,
                                      input logic [7:0]  code_b);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if ((codes[8*k +: 8] == code_a) || (codes[8*k +: 8] == code_b)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage : input_ctrl_pkg
`default_nettype wire

// File: rtl/input_ctrl_frame_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_gen
//  Description : Brings the asynchronous frame strobe into the Clk domain
//                through a two-flop synchronizer and turns its rising edge
//                into a registered single-cycle frame_tick. frame_tick is
//                high on the third Clk edge after frame_clk rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic r_sync_meta;
    logic r_sync_out;
    logic r_sync_last;
    logic r_tick;

    // Two-flop synchronizer for the asynchronous frame strobe
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync_meta <= 1'b0;
            r_sync_out  <= 1'b0;
        end else begin
            r_sync_meta <= frame_clk;
            r_sync_out  <= r_sync_meta;
        end
    end

    // Registered rising-edge detect; clearing r_sync_last in reset means a
    // strobe already high at reset release still yields one tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync_last <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_sync_last <= r_sync_out;
            r_tick      <= r_sync_out & ~r_sync_last;
        end
    end

    assign frame_tick = r_tick;

endmodule : frame_tick_gen
`default_nettype wire

// File: rtl/input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : input_ctrl
//  Description : Keyboard-to-control front end. Scans the four-slot keycode
//                report once per frame tick and produces frame-stable
//                left/right levels plus a one-Clk fire pulse with a
//                configurable cooldown between accepted shots.
//                Optional feature macro: INPUT_CTRL_AUTOFIRE_EN - when
//                defined, holding the fire key re-fires after every
//                cooldown instead of requiring a release between shots.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_ctrl
    import input_ctrl_pkg::*;
#(
    parameter int unsigned FIRE_COOLDOWN = 8,
    parameter int unsigned CD_W          = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [31:0] keycodes,
    output logic        left,
    output logic        right,
    output logic        fire
);

    localparam logic [CD_W-1:0] c_cd_load = CD_W'(FIRE_COOLDOWN);
    localparam logic [CD_W-1:0] c_cd_one  = CD_W'(1);

    logic            w_frame_tick;
    logic            w_l;
    logic            w_r;
    logic            w_f;
    logic            w_cd_zero;
    logic            w_shot;
    dir_t            w_dir_next;

    dir_t            r_state;
    logic            r_l_prev;
    logic            r_r_prev;
    logic            r_f_prev;
    logic            r_left;
    logic            r_right;
    logic            r_fire;
    logic [CD_W-1:0] r_cd;

    frame_tick_gen u_frame_tick_gen (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (w_frame_tick)
    );

    // Key presence decode; both arrow keys and WASD-style letters count
    assign w_l = key_held(keycodes, KEY_LEFT,  KEY_A);
    assign w_r = key_held(keycodes, KEY_RIGHT, KEY_D);
    assign w_f = key_held(keycodes, KEY_SPACE, KEY_SPACE);

    assign w_cd_zero = (r_cd == '0);

`ifdef INPUT_CTRL_AUTOFIRE_EN
    // Holding fire repeats as soon as the cooldown has expired
    assign w_shot = w_f & w_cd_zero;

    logic w_unused_f_prev;
    assign w_unused_f_prev = r_f_prev;
`else
    // Each shot needs a fresh press: fire must have been absent last tick
    assign w_shot = w_f & w_cd_zero & ~r_f_prev;
`endif

    // Direction next-state: fixed left priority on a simultaneous press
    // from idle, otherwise the most recently pressed direction wins
    always_comb begin
        w_dir_next = r_state;
        case (r_state)
            D_NONE: begin
                if (w_l) begin
                    w_dir_next = D_LEFT;
                end else if (w_r) begin
                    w_dir_next = D_RIGHT;
                end
            end
            D_LEFT: begin
                if (!w_l && w_r) begin
                    w_dir_next = D_RIGHT;
                end else if (!w_l && !w_r) begin
                    w_dir_next = D_NONE;
                end else if (w_l && w_r && !r_r_prev) begin
                    w_dir_next = D_RIGHT;
                end
            end
            D_RIGHT: begin
                if (!w_r && w_l) begin
                    w_dir_next = D_LEFT;
                end else if (!w_r && !w_l) begin
                    w_dir_next = D_NONE;
                end else if (w_l && w_r && !r_l_prev) begin
                    w_dir_next = D_LEFT;
                end
            end
            default: begin
                w_dir_next = D_NONE;
            end
        endcase
    end

    // Direction FSM with registered one-hot style level outputs, frame-gated
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= D_NONE;
            r_l_prev <= 1'b0;
            r_r_prev <= 1'b0;
            r_left   <= 1'b0;
            r_right  <= 1'b0;
        end else if (w_frame_tick) begin
            r_state  <= w_dir_next;
            r_l_prev <= w_l;
            r_r_prev <= w_r;
            r_left   <= (w_dir_next == D_LEFT);
            r_right  <= (w_dir_next == D_RIGHT);
        end
    end

    // Fire pulse and saturating cooldown counter; a shot reloads the
    // counter instead of decrementing it on the same tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cd     <= '0;
            r_f_prev <= 1'b0;
            r_fire   <= 1'b0;
        end else begin
            r_fire <= 1'b0;
            if (w_frame_tick) begin
                r_f_prev <= w_f;
                if (w_shot) begin
                    r_fire <= 1'b1;
                    r_cd   <= c_cd_load;
                end else if (!w_cd_zero) begin
                    r_cd <= r_cd - c_cd_one;
                end
            end
        end
    end

    assign left  = r_left;
    assign right = r_right;
    assign fire  = r_fire;

endmodule : input_ctrl
`default_nettype wire
